// File: rtl/bitrev_stream_engine.sv
// Serial-bit to WIDTH-bit word assembler with optional bit reversal and a FWFT FIFO.
// Optional per-entry parity output is enabled by defining BITREV_PARITY_EN.
module bitrev_stream_engine #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              bit_ready,
   input  logic              msb_first,
   input  logic              rev_en,
   input  logic              flush,
   output logic [WIDTH-1:0]  word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [ADDR_W:0]   count
`ifdef BITREV_PARITY_EN
   ,
   output logic              parity_out
`endif
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [ADDR_W:0]   FULL     = (ADDR_W + 1)'(DEPTH);

   logic [CNT_W-1:0]  bit_cnt;
   logic [WIDTH-1:0]  shift;
   logic [WIDTH-1:0]  asm_word;
   logic [WIDTH-1:0]  store_word;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              accept;
   logic              push;
   logic              pop;

   // Only the completing bit can stall; partial assembly continues while full.
   assign bit_ready  = (bit_cnt != LAST_BIT) || (count != FULL);
   assign accept     = bit_valid && bit_ready && !flush;
   assign push       = accept && (bit_cnt == LAST_BIT);
   assign word_valid = (count != '0);
   assign pop        = word_valid && word_ready;
   assign word_out   = word_valid ? mem[rd_ptr] : '0;

   always_comb begin
      asm_word = msb_first ? {shift[WIDTH-2:0], bit_in} : {bit_in, shift[WIDTH-1:1]};
      store_word = asm_word;
      if (rev_en)
         for (int i = 0; i < WIDTH; i++) store_word[i] = asm_word[WIDTH-1-i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
         shift   <= '0;
      end else if (flush || push) begin
         bit_cnt <= '0;
         shift   <= '0;
      end else if (accept) begin
         bit_cnt <= bit_cnt + 1'b1;
         shift   <= asm_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr] <= store_word;
   end

`ifdef BITREV_PARITY_EN
   logic pmem [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset && push) pmem[wr_ptr] <= ^store_word;
   end

   assign parity_out = word_valid ? pmem[rd_ptr] : 1'b0;
`endif

endmodule
